// File: rtl/regfile_pkg.sv
// Shared constants and index type for the multiport register file.
// Imported by regfile_multiport and regfile_scoreboard.
package regfile_pkg;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_DEPTH    = 32;
  localparam int DEF_ADDR_W   = $clog2(DEF_DEPTH);
  localparam int DEF_LINK_REG = DEF_DEPTH - 1;
  localparam int ZERO_REG     = 0;
  localparam int MAX_READ     = 4;

  typedef logic [DEF_ADDR_W-1:0] reg_idx_t;

  // One-hot decode of a register index, bit 0 (zero reg) masked off.
  function automatic logic [DEF_DEPTH-1:0] idx_onehot(
    input reg_idx_t idx,
    input logic     en
  );
    logic [DEF_DEPTH-1:0] v;
    v = '0;
    if (en && idx != reg_idx_t'(ZERO_REG))
      v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write scoreboard for RAW hazard detection.
// Ports: Clock, Resetn (sync, active-low), Issue_Valid/Issue_Reg (set),
//   Write_Hit (per-register clear), Pending_Vec (state).
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Issue_Valid,
  input  logic [ADDR_W-1:0] Issue_Reg,
  input  logic [DEPTH-1:0]  Write_Hit,
  output logic [DEPTH-1:0]  Pending_Vec
);

  logic [DEPTH-1:0] set_vec;
  logic [DEPTH-1:0] pend_d;
  logic [DEPTH-1:0] pend_q;

  always_comb begin
    set_vec = '0;
    for (int i = 1; i < DEPTH; i++)
      set_vec[i] = Issue_Valid &&
                   (Issue_Reg == ADDR_W'(i));
  end

  // A new producer issuing on the same edge that an older one
  // retires keeps the bit set: set wins over clear.
  always_comb begin
    pend_d = '0;
    for (int i = 1; i < DEPTH; i++)
      pend_d[i] = set_vec[i] |
                  (pend_q[i] & ~Write_Hit[i]);
  end

  always_ff @(negedge Clock) begin
    if (!Resetn)
      pend_q <= '0;
    else
      pend_q <= pend_d;
  end

  assign Pending_Vec = pend_q;

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised multiport register file with link port and scoreboard.
// Ports: Clock, Resetn (sync, active-low, falling edge); ReadReg/
//   ReadData/ReadPending (NUM_READ ports); WriteReg/WriteData/
//   Reg_write_Control (general write); Link_Store/Link_WriteData
//   (write to LINK_REG); Issue_Valid/Issue_Reg (scoreboard set);
//   Pending_Vec (full scoreboard).
// Option: define REGFILE_BYPASS_EN to forward same-cycle write data.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  localparam int ADDR_W  = $clog2(DEPTH),
  parameter int NUM_READ = 2,
  parameter int LINK_REG = DEPTH - 1
) (
  input  logic                       Clock,
  input  logic                       Resetn,
  input  logic [NUM_READ*ADDR_W-1:0] ReadReg,
  output logic [NUM_READ*WIDTH-1:0]  ReadData,
  output logic [NUM_READ-1:0]        ReadPending,
  input  logic [ADDR_W-1:0]          WriteReg,
  input  logic [WIDTH-1:0]           WriteData,
  input  logic                       Reg_write_Control,
  input  logic                       Link_Store,
  input  logic [WIDTH-1:0]           Link_WriteData,
  input  logic                       Issue_Valid,
  input  logic [ADDR_W-1:0]          Issue_Reg,
  output logic [DEPTH-1:0]           Pending_Vec
);

  localparam logic [ADDR_W-1:0] LINK_IDX = ADDR_W'(LINK_REG);
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic [WIDTH-1:0] regs [DEPTH];
  logic             gen_en;
  logic             link_en;
  logic [DEPTH-1:0] wr_hit;

  // Link port owns LINK_REG when both ports target it.
  assign link_en = Link_Store && (LINK_IDX != ZERO_IDX);
  assign gen_en  = Reg_write_Control &&
                   (WriteReg != ZERO_IDX) &&
                   !(link_en && WriteReg == LINK_IDX);

  always_ff @(negedge Clock) begin
    if (!Resetn) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else begin
      if (gen_en)
        regs[WriteReg] <= WriteData;
      if (link_en)
        regs[LINK_IDX] <= Link_WriteData;
    end
  end

  always_comb begin
    wr_hit = '0;
    if (gen_en)
      wr_hit[WriteReg] = 1'b1;
    if (link_en)
      wr_hit[LINK_IDX] = 1'b1;
  end

  regfile_scoreboard #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_sb (
    .Clock       (Clock),
    .Resetn      (Resetn),
    .Issue_Valid (Issue_Valid),
    .Issue_Reg   (Issue_Reg),
    .Write_Hit   (wr_hit),
    .Pending_Vec (Pending_Vec)
  );

  always_comb begin
    ReadData    = '0;
    ReadPending = '0;
    for (int k = 0; k < NUM_READ; k++) begin
      logic [ADDR_W-1:0] idx;
      idx = ReadReg[k*ADDR_W +: ADDR_W];
      ReadPending[k] = Pending_Vec[idx];
      if (idx == ZERO_IDX) begin
        ReadData[k*WIDTH +: WIDTH] = '0;
        ReadPending[k] = 1'b0;
      end
`ifdef REGFILE_BYPASS_EN
      else if (link_en && idx == LINK_IDX) begin
        ReadData[k*WIDTH +: WIDTH] = Link_WriteData;
        ReadPending[k] = 1'b0;
      end else if (gen_en && idx == WriteReg) begin
        ReadData[k*WIDTH +: WIDTH] = WriteData;
        ReadPending[k] = 1'b0;
      end
`endif
      else begin
        ReadData[k*WIDTH +: WIDTH] = regs[idx];
      end
    end
  end

endmodule
